// File: rtl/ahb_apb_arbiter.sv
// ahb_apb_arbiter
// Grants the shared APB master port of the multi-AHB bridge to one of NUM_REQ
// AHB-side requesters at a time. Supports round-robin (ARB_TYPE=0) and
// weighted round-robin (ARB_TYPE=1). It honours locked (HMASTLOCK) sequences
// for up to MAX_LOCK consecutive transfers. The grant is released or handed
// off on APB transfer completion.
//
// Ports:
//   HCLK       in   clock
//   HRESETn    in   synchronous active-low reset
//   req        in   [NUM_REQ]  pending APB transfer per requester (level)
//   lock       in   [NUM_REQ]  requester's current transfer is locked
//   xfer_done  in   one-cycle pulse: granted APB transfer completed
//   gnt        out  [NUM_REQ]  one-hot registered grant
//   gnt_idx    out  [IDX_W]    binary index of the owner (0 when no grant)
//   gnt_valid  out  a grant is active
//   locked     out  current owner is held by a lock
//   lock_err   out  one-cycle pulse: lock broken by MAX_LOCK timeout
module ahb_apb_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ARB_TYPE = 0,
  parameter int WEIGHT_W = 4,
  parameter logic [NUM_REQ*WEIGHT_W-1:0] WEIGHTS = {NUM_REQ{WEIGHT_W'(1)}},
  parameter int MAX_LOCK = 16,
  parameter int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic               xfer_done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               locked,
  output logic               lock_err
);

  localparam int unsigned N      = NUM_REQ;
  localparam int          LCNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(MAX_LOCK - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic {S_IDLE, S_OWN} state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic                valid_q;
  logic                locked_q;
  logic                lock_err_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [WEIGHT_W-1:0] credit_q;
  logic [LCNT_W-1:0]   lcnt_q;

  logic [IDX_W-1:0]    ptr_nxt_d;
  logic [IDX_W-1:0]    idle_win_d;
  logic [IDX_W-1:0]    hand_win_d;
  logic [WEIGHT_W-1:0] idle_credit_d;
  logic [WEIGHT_W-1:0] hand_credit_d;
  logic                own_req_d;
  logic                own_lock_d;

  // First asserted request scanning upward from start, wrapping at NUM_REQ.
  // Scanning in reverse lets the closest hit overwrite farther ones.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] res;
    int unsigned      idx;
    res = start;
    for (int unsigned k = N; k > 0; k--) begin
      idx = (32'(start) + k - 1) % N;
      if (r[IDX_W'(idx)]) res = IDX_W'(idx);
    end
    return res;
  endfunction

  // Credit = extra consecutive transfers beyond the first; weight 0 acts as 1.
  function automatic logic [WEIGHT_W-1:0] credit_for(input logic [IDX_W-1:0] w);
    logic [WEIGHT_W-1:0] wt;
    wt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w == IDX_W'(i)) wt = WEIGHTS[i*WEIGHT_W +: WEIGHT_W];
    end
    if (ARB_TYPE == 0 || wt == '0) return '0;
    return wt - 1'b1;
  endfunction

  always_comb begin
    ptr_nxt_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    idle_win_d    = pick(req, ptr_q);
    // Owner sits last in a scan starting at owner+1, so it only wins again
    // when nobody else is requesting.
    hand_win_d    = pick(req, ptr_nxt_d);
    idle_credit_d = credit_for(idle_win_d);
    hand_credit_d = credit_for(hand_win_d);
    own_req_d     = req[idx_q];
    own_lock_d    = lock[idx_q];
  end

  always_ff @(posedge HCLK) begin
    lock_err_q <= 1'b0;
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ptr_q    <= '0;
      credit_q <= '0;
      lcnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            state_q  <= S_OWN;
            gnt_q    <= NUM_REQ'(1) << idle_win_d;
            idx_q    <= idle_win_d;
            valid_q  <= 1'b1;
            locked_q <= 1'b0;
            credit_q <= idle_credit_d;
            lcnt_q   <= '0;
          end
        end
        S_OWN: begin
          if (!xfer_done) begin
            if (!own_req_d) begin
              state_q  <= S_IDLE;
              gnt_q    <= '0;
              idx_q    <= '0;
              valid_q  <= 1'b0;
              locked_q <= 1'b0;
              ptr_q    <= ptr_nxt_d;
            end
          end else if (own_lock_d && own_req_d && lcnt_q < LCNT_MAX) begin
            lcnt_q   <= lcnt_q + 1'b1;
            locked_q <= 1'b1;
          end else if (own_req_d && !own_lock_d && credit_q != '0) begin
            // A locked request at the lock limit must rotate, so credit
            // only applies to unlocked requests.
            credit_q <= credit_q - 1'b1;
            locked_q <= 1'b0;
          end else begin
            ptr_q      <= ptr_nxt_d;
            locked_q   <= 1'b0;
            lock_err_q <= own_lock_d && own_req_d;
            if (|req) begin
              gnt_q    <= NUM_REQ'(1) << hand_win_d;
              idx_q    <= hand_win_d;
              credit_q <= hand_credit_d;
              lcnt_q   <= '0;
            end else begin
              state_q <= S_IDLE;
              gnt_q   <= '0;
              idx_q   <= '0;
              valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign locked    = locked_q;
  assign lock_err  = lock_err_q;

endmodule
